// File: rtl/im_access_arbiter.sv
// Instruction-memory access arbiter: boot loader, IF fetch port and debug park share one SRAM port.
// Optional macro IM_FAULT_TRAP_EN: report fetch faults and trap the FSM into DEBUG on a faulted fetch.
module im_access_arbiter #(
  parameter int          DEPTH = 256,
  parameter int          AW    = 8,
  parameter logic [31:0] NOP   = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fetch_req,
  input  logic [31:0]   fetch_addr,
  input  logic          fetch_flush,
  output logic          fetch_gnt,
  output logic          fetch_valid,
  output logic [31:0]   fetch_instr,
  output logic          fetch_fault,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_wdata,
  output logic          ld_ready,
  input  logic          ld_done,
  input  logic          dbg_req,
  output logic          dbg_ack,
  output logic [AW:0]   ld_count,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;
  localparam logic [1:0] S_DEBUG = 2'd3;

  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);
  localparam logic [AW:0] CNT_MAX    = (AW + 1)'(DEPTH);

  logic [1:0]  state_q, state_d;
  logic        rsp_vld_q, rsp_vld_d;
  logic        rsp_fault_q, rsp_fault_d;
  logic [AW:0] ld_count_q, ld_count_d;
  logic        addr_fault;
`ifdef IM_FAULT_TRAP_EN
  logic        trap_q, trap_d;
`endif

  always_comb begin
    addr_fault = (fetch_addr >= ADDR_LIMIT) || (fetch_addr[1:0] != 2'b00);
  end

  always_comb begin
    state_d   = state_q;
    fetch_gnt = 1'b0;
    ld_ready  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = ld_addr;
    mem_wdata = ld_wdata;
`ifdef IM_FAULT_TRAP_EN
    trap_d    = trap_q;
`endif
    case (state_q)
      S_BOOT: begin
        ld_ready = ld_we;
        mem_en   = ld_we;
        mem_we   = ld_we;
        // ld_done wins over dbg_req: debug is only honoured once RUN is reached
        if (ld_done) state_d = S_RUN;
      end
      S_RUN: begin
        mem_addr = fetch_addr[AW+1:2];
        if (dbg_req) begin
          state_d = S_HALT;
        end else begin
          fetch_gnt = fetch_req;
          mem_en    = fetch_req && !addr_fault;
`ifdef IM_FAULT_TRAP_EN
          // a flushed (wrong-path) faulting fetch must not trap
          if (fetch_req && addr_fault && !fetch_flush) begin
            state_d = S_HALT;
            trap_d  = 1'b1;
          end
`endif
        end
      end
      S_HALT: begin
        state_d = S_DEBUG;
      end
      S_DEBUG: begin
        ld_ready = ld_we;
        mem_en   = ld_we;
        mem_we   = ld_we;
`ifdef IM_FAULT_TRAP_EN
        // a trap is released by a debug request/release handshake
        if (dbg_req) trap_d = 1'b0;
        if (!dbg_req && !trap_q) state_d = S_RUN;
`else
        if (!dbg_req) state_d = S_RUN;
`endif
      end
      default: state_d = S_BOOT;
    endcase
    if (reset) begin
      fetch_gnt = 1'b0;
      ld_ready  = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
    end
  end

  always_comb begin
    rsp_vld_d   = fetch_gnt && !fetch_flush;
    rsp_fault_d = fetch_gnt && addr_fault;
    ld_count_d  = ld_count_q;
    if (ld_ready && (ld_count_q != CNT_MAX)) ld_count_d = ld_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_BOOT;
      rsp_vld_q   <= 1'b0;
      rsp_fault_q <= 1'b0;
      ld_count_q  <= '0;
`ifdef IM_FAULT_TRAP_EN
      trap_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_fault_q <= rsp_fault_d;
      ld_count_q  <= ld_count_d;
`ifdef IM_FAULT_TRAP_EN
      trap_q      <= trap_d;
`endif
    end
  end

  // reset also masks a response already registered, so nothing stale escapes
  always_comb begin
    fetch_valid = rsp_vld_q && !reset;
    fetch_instr = '0;
    if (fetch_valid) fetch_instr = rsp_fault_q ? NOP : mem_rdata;
`ifdef IM_FAULT_TRAP_EN
    fetch_fault = fetch_valid && rsp_fault_q;
`else
    fetch_fault = 1'b0;
`endif
    dbg_ack  = (state_q == S_DEBUG) && !reset;
    ld_count = ld_count_q;
  end

endmodule

// File: tb/tb_im_access_arbiter.sv
// Directed bench for im_access_arbiter with a behavioural synchronous-read SRAM.
module tb_im_access_arbiter;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_req, fetch_flush, fetch_gnt, fetch_valid, fetch_fault;
  logic [31:0]   fetch_addr, fetch_instr;
  logic          ld_we, ld_ready, ld_done, dbg_req, dbg_ack;
  logic [AW-1:0] ld_addr, mem_addr;
  logic [31:0]   ld_wdata, mem_wdata, mem_rdata;
  logic [AW:0]   ld_count;
  logic          mem_en, mem_we;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [256];
  logic [31:0] w [4];

  im_access_arbiter dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_flush(fetch_flush),
    .fetch_gnt(fetch_gnt), .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
    .fetch_fault(fetch_fault),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ready(ld_ready),
    .ld_done(ld_done), .dbg_req(dbg_req), .dbg_ack(dbg_ack), .ld_count(ld_count),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

`ifdef IM_FAULT_TRAP_EN
  // cycle after the faulted response: parked in DEBUG, then release via dbg_req pulse
  task automatic trap_exit();
    cyc(); settle();
    chk("trap_dbg_ack", {31'b0, dbg_ack}, 32'd1);
    dbg_req = 1'b1;
    cyc(); dbg_req = 1'b0;
    cyc();
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem_rdata = 32'h0;
    w[0] = 32'h20080005; w[1] = 32'h20090007; w[2] = 32'h01095020; w[3] = 32'hAC0A0010;
    reset = 1'b1; fetch_req = 0; fetch_addr = 0; fetch_flush = 0;
    ld_we = 0; ld_addr = 0; ld_wdata = 0; ld_done = 0; dbg_req = 0;

    // T1 reset
    cyc(); cyc(); settle();
    chk("rst_valid", {31'b0, fetch_valid}, 32'd0);
    chk("rst_instr", fetch_instr, 32'd0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
    chk("rst_ld_ready", {31'b0, ld_ready}, 32'd0);
    chk("rst_dbg_ack", {31'b0, dbg_ack}, 32'd0);
    chk("rst_ld_count", {23'b0, ld_count}, 32'd0);
    chk("rst_mem_en", {30'b0, mem_en, mem_we}, 32'd0);
    cyc(); reset = 1'b0; fetch_req = 1'b1; fetch_addr = 32'd0; settle();
    chk("boot_no_gnt", {31'b0, fetch_gnt}, 32'd0);
    chk("boot_no_mem_en", {31'b0, mem_en}, 32'd0);

    // T2 boot load, ld_done on the last write
    for (int i = 0; i < 4; i++) begin
      cyc(); fetch_req = 1'b0;
      ld_we = 1'b1; ld_addr = AW'(i); ld_wdata = w[i]; ld_done = (i == 3); settle();
      chk("boot_wr", {29'b0, ld_ready, mem_en, mem_we}, 32'd7);
    end
    cyc(); ld_we = 1'b0; ld_done = 1'b0;
    fetch_req = 1'b1; fetch_addr = 32'd0; settle();
    chk("boot_ld_count", {23'b0, ld_count}, 32'd4);
    chk("run_gnt", {31'b0, fetch_gnt}, 32'd1);
    chk("run_mem_en", {30'b0, mem_en, mem_we}, 32'd2);
    cyc(); fetch_req = 1'b0; settle();
    chk("t2_valid", {31'b0, fetch_valid}, 32'd1);
    chk("t2_instr", fetch_instr, w[0]);

    // T3 streaming, flush with the 2nd grant kills that grant's response
    for (int k = 0; k < 4; k++) begin
      cyc(); fetch_req = 1'b1; fetch_addr = 32'(4 * k); fetch_flush = (k == 1); settle();
      chk("t3_gnt", {31'b0, fetch_gnt}, 32'd1);
      if (k == 2) begin
        chk("t3_flushed", {31'b0, fetch_valid}, 32'd0);
      end else if (k > 0) begin
        chk("t3_valid", {31'b0, fetch_valid}, 32'd1);
        chk("t3_instr", fetch_instr, w[k-1]);
      end
    end
    cyc(); fetch_req = 1'b0; fetch_flush = 1'b0; settle();
    chk("t3_last_valid", {31'b0, fetch_valid}, 32'd1);
    chk("t3_last_instr", fetch_instr, w[3]);

    // T4 debug park and patch
    cyc(); fetch_req = 1'b1; fetch_addr = 32'd8; settle();
    chk("t4_gnt", {31'b0, fetch_gnt}, 32'd1);
    cyc(); fetch_addr = 32'd12; dbg_req = 1'b1; settle();
    chk("t4_dbg_no_gnt", {31'b0, fetch_gnt}, 32'd0);
    chk("t4_outstanding", fetch_instr, w[2]);
    cyc(); settle();
    chk("t4_halt", {29'b0, fetch_gnt, fetch_valid, dbg_ack}, 32'd0);
    cyc(); ld_we = 1'b1; ld_addr = 8'd1; ld_wdata = 32'hDEADBEEF; settle();
    chk("t4_debug", {29'b0, dbg_ack, fetch_gnt, ld_ready}, 32'd5);
    cyc(); ld_we = 1'b0; dbg_req = 1'b0; settle();
    chk("t4_ack_hold", {31'b0, dbg_ack}, 32'd1);
    cyc(); fetch_addr = 32'd4; settle();
    chk("t4_resume", {30'b0, fetch_gnt, dbg_ack}, 32'd2);
    chk("t4_ld_count", {23'b0, ld_count}, 32'd5);
    cyc(); fetch_req = 1'b0; settle();
    chk("t4_patched", fetch_instr, 32'hDEADBEEF);

    // T5 faults: out of range, misaligned, then last legal word and a normal read
    cyc(); fetch_req = 1'b1; fetch_addr = 32'd1024; settle();
    chk("t5_oor_gnt", {30'b0, fetch_gnt, mem_en}, 32'd2);
    cyc(); fetch_req = 1'b0; settle();
    chk("t5_oor_valid", {31'b0, fetch_valid}, 32'd1);
    chk("t5_oor_instr", fetch_instr, 32'd0);
`ifdef IM_FAULT_TRAP_EN
    chk("t5_oor_fault", {31'b0, fetch_fault}, 32'd1);
    trap_exit();
`else
    chk("t5_oor_fault", {31'b0, fetch_fault}, 32'd0);
    cyc();
`endif
    fetch_req = 1'b1; fetch_addr = 32'd6; settle();
    chk("t5_mis_gnt", {30'b0, fetch_gnt, mem_en}, 32'd2);
    cyc(); fetch_req = 1'b0; settle();
    chk("t5_mis_valid", {31'b0, fetch_valid}, 32'd1);
    chk("t5_mis_instr", fetch_instr, 32'd0);
`ifdef IM_FAULT_TRAP_EN
    chk("t5_mis_fault", {31'b0, fetch_fault}, 32'd1);
    trap_exit();
`else
    chk("t5_mis_fault", {31'b0, fetch_fault}, 32'd0);
    cyc();
`endif
    fetch_req = 1'b1; fetch_addr = 32'd1020; settle();
    chk("t5_edge_mem", {30'b0, fetch_gnt, mem_en}, 32'd3);
    chk("t5_edge_addr", {24'b0, mem_addr}, 32'd255);
    cyc(); fetch_addr = 32'd8; settle();
    chk("t5_edge_resp", {30'b0, fetch_valid, fetch_fault}, 32'd2);
    cyc(); fetch_req = 1'b0; settle();
    chk("t5_after", fetch_instr, w[2]);

    // T6 reset aborts an in-flight read, saturation, reset in HALT_PEND
    cyc(); fetch_req = 1'b1; fetch_addr = 32'd0; settle();
    chk("t6_gnt", {31'b0, fetch_gnt}, 32'd1);
    cyc(); reset = 1'b1; fetch_req = 1'b0; settle();
    chk("t6_abort", {31'b0, fetch_valid}, 32'd0);
    for (int i = 0; i < 300; i++) begin
      cyc(); reset = 1'b0;
      ld_we = 1'b1; ld_addr = i[7:0]; ld_wdata = 32'(i); settle();
      if (i == 255) chk("t6_cnt_255", {23'b0, ld_count}, 32'd255);
    end
    cyc(); ld_we = 1'b0; ld_done = 1'b1; dbg_req = 1'b1; settle();
    chk("t6_cnt_sat", {23'b0, ld_count}, 32'd256);
    cyc(); ld_done = 1'b0; dbg_req = 1'b0; fetch_req = 1'b1; fetch_addr = 32'd0; settle();
    chk("t6_boot_dbg_to_run", {30'b0, fetch_gnt, dbg_ack}, 32'd2);
    cyc(); fetch_req = 1'b0; dbg_req = 1'b1; settle();
    chk("t6_word0", fetch_instr, 32'h100);
    cyc(); reset = 1'b1; dbg_req = 1'b0; fetch_req = 1'b1; settle();
    chk("t6_halt_rst", {30'b0, fetch_valid, fetch_gnt}, 32'd0);
    cyc(); reset = 1'b0; settle();
    chk("t6_post_rst", {29'b0, fetch_gnt, fetch_valid, dbg_ack}, 32'd0);
    chk("t6_post_cnt", {23'b0, ld_count}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
